// File: rtl/acq_write_ctrl.sv
// ---------------------------------------------------------------------------
// acq_write_ctrl
//
// Capture controller for a single-port acquisition RAM. After Start, the block
// arms, waits for a trigger, then writes DEPTH = 2**RAM_ADDR_BITS consecutive
// upstream samples into the RAM at addresses 0..DEPTH-1. It then signals Done
// and holds until the next Start.
//
// Configuration macro: ACQ_TRIGGER_EN
//   defined   : ARMED waits for Trig=1 before moving to ACQ.
//   undefined : ARMED lasts exactly one cycle. The Trig port stays in the
//               port list but has no effect.
//
// Upstream handshake (valid/ready):
//   A sample is transferred on a rising edge where SampleValid and SampleReady
//   are both high. SampleReady is a combinational function of the state only.
//   It is high only in ACQ and never depends on SampleValid. SampleValid is
//   ignored whenever SampleReady is low. The upstream keeps SampleIn stable
//   while SampleValid is high and the sample has not been accepted.
//
// RAM write port:
//   WrtEna, WrtAddrs and DatIn are registered. A sample accepted at edge N
//   is presented to the RAM during the cycle after edge N, and the RAM
//   captures it at edge N+1. WrtAddrs and DatIn keep their last values while
//   WrtEna is low.
//
// The FSM state is exposed on dbg_state_o for checkers.
// ---------------------------------------------------------------------------
module acq_write_ctrl #(
   parameter int RAM_WIDTH     = 32,
   parameter int RAM_ADDR_BITS = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     Start,
   input  logic                     Trig,
   input  logic [RAM_WIDTH-1:0]     SampleIn,
   input  logic                     SampleValid,
   output logic                     SampleReady,
   output logic [RAM_ADDR_BITS-1:0] WrtAddrs,
   output logic                     WrtEna,
   output logic [RAM_WIDTH-1:0]     DatIn,
   output logic                     Busy,
   output logic                     Done,
   output logic [RAM_ADDR_BITS:0]   WordCount,
   output logic [2:0]               dbg_state_o
);

   localparam int DEPTH = 2 ** RAM_ADDR_BITS;
   localparam int CNT_W = RAM_ADDR_BITS + 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARMED = 3'd1,
      S_ACQ   = 3'd2,
      S_FLUSH = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   state_e                   state_q, state_d;
   logic                     wrt_ena_q, wrt_ena_d;
   logic [RAM_ADDR_BITS-1:0] wrt_addrs_q, wrt_addrs_d;
   logic [RAM_WIDTH-1:0]     dat_in_q, dat_in_d;
   logic [CNT_W-1:0]         word_count_q, word_count_d;

   logic                     ready;
   logic                     accept;
   logic                     last_word;
   logic                     arm_req;

   // Handshake terms: ready depends on the state only, and accept is the
   // transfer condition.
   assign ready     = (state_q == S_ACQ);
   assign accept    = ready & SampleValid;
   // The sample being accepted fills the final RAM location.
   assign last_word = (word_count_q == CNT_W'(DEPTH - 1));
   // Start is acted on only from IDLE or DONE and is ignored elsewhere.
   assign arm_req   = Start & ((state_q == S_IDLE) | (state_q == S_DONE));

`ifndef ACQ_TRIGGER_EN
   // Trig has no effect when trigger support is compiled out.
   logic unused_trig;
   assign unused_trig = Trig;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (Start) state_d = S_ARMED;
         end
         S_ARMED: begin
            // Trig is sampled only here. A Trig that arrives together with
            // Start in IDLE/DONE takes effect one cycle later.
`ifdef ACQ_TRIGGER_EN
            if (Trig) state_d = S_ACQ;
`else
            state_d = S_ACQ;
`endif
         end
         S_ACQ: begin
            if (accept && last_word) state_d = S_FLUSH;
         end
         S_FLUSH: begin
            // The final RAM write is on the port during this cycle. Done is
            // raised only after that write completes.
            state_d = S_DONE;
         end
         S_DONE: begin
            if (Start) state_d = S_ARMED;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      SampleReady = 1'b0;
      Busy        = 1'b0;
      Done        = 1'b0;
      case (state_q)
         S_ARMED: Busy = 1'b1;
         S_ACQ: begin
            Busy        = 1'b1;
            SampleReady = 1'b1;
         end
         S_FLUSH: Busy = 1'b1;
         S_DONE:  Done = 1'b1;
         default: ;
      endcase
   end

   // Write-port and counter next values.
   always_comb begin
      wrt_ena_d    = accept;
      wrt_addrs_d  = wrt_addrs_q;
      dat_in_d     = dat_in_q;
      word_count_d = word_count_q;
      if (accept) begin
         // The count before the increment is the address of this sample, so
         // addresses run 0..DEPTH-1 with no gaps. Stalls leave the count
         // unchanged.
         wrt_addrs_d  = word_count_q[RAM_ADDR_BITS-1:0];
         dat_in_d     = SampleIn;
         word_count_d = word_count_q + CNT_W'(1);
      end else if (arm_req) begin
         // Clear the count on entry to ARMED. No accept can occur in
         // IDLE/DONE, so this branch never conflicts with a write.
         word_count_d = '0;
      end
   end

   // Write-port and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrt_ena_q    <= 1'b0;
         wrt_addrs_q  <= '0;
         dat_in_q     <= '0;
         word_count_q <= '0;
      end else begin
         wrt_ena_q    <= wrt_ena_d;
         wrt_addrs_q  <= wrt_addrs_d;
         dat_in_q     <= dat_in_d;
         word_count_q <= word_count_d;
      end
   end

   assign WrtEna      = wrt_ena_q;
   assign WrtAddrs    = wrt_addrs_q;
   assign DatIn       = dat_in_q;
   assign WordCount   = word_count_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_acq_write_ctrl.sv
// ---------------------------------------------------------------------------
// tb_acq_write_ctrl
//
// Inputs are driven on the falling edge. Outputs are compared on the falling
// edge against a cycle-level reference model of the capture behaviour. A
// scoreboard queue holds the expected {address, data} of each RAM write. A
// bench-side RAM, filled from the DUT write port, is compared with the
// expected capture image once each capture finishes.
// ---------------------------------------------------------------------------
module tb_acq_write_ctrl;

   localparam int W     = 32;
   localparam int AB    = 4;
   localparam int DEPTH = 2 ** AB;

   // Reference model phases.
   localparam int P_IDLE  = 0;
   localparam int P_ARMED = 1;
   localparam int P_ACQ   = 2;
   localparam int P_FLUSH = 3;
   localparam int P_DONE  = 4;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          trig;
   logic [W-1:0]  sample_in;
   logic          sample_valid;
   logic          sample_ready;
   logic [AB-1:0] wrt_addrs;
   logic          wrt_ena;
   logic [W-1:0]  dat_in;
   logic          busy;
   logic          done;
   logic [AB:0]   word_count;
   logic [2:0]    dbg_state;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state.
   int            m_phase;
   int            m_count;
   logic          m_wena;
   logic [AB-1:0] m_addr;
   logic [W-1:0]  m_data;
   logic [W-1:0]  exp_ram[DEPTH];
   logic [W-1:0]  ram[DEPTH];
   logic [AB+W-1:0] exp_q[$];

   acq_write_ctrl #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .Start       (start),
      .Trig        (trig),
      .SampleIn    (sample_in),
      .SampleValid (sample_valid),
      .SampleReady (sample_ready),
      .WrtAddrs    (wrt_addrs),
      .WrtEna      (wrt_ena),
      .DatIn       (dat_in),
      .Busy        (busy),
      .Done        (done),
      .WordCount   (word_count),
      .dbg_state_o (dbg_state)
   );

   // Clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      m_phase = P_IDLE;
      m_count = 0;
      m_wena  = 1'b0;
      m_addr  = '0;
      m_data  = '0;
      exp_q.delete();
   endtask

   // Compare every DUT output with the model and score any RAM write.
   task automatic observe();
      logic [AB+W-1:0] e;
      check("ready", sample_ready, 64'(m_phase == P_ACQ));
      check("busy",  busy, 64'(m_phase == P_ARMED || m_phase == P_ACQ || m_phase == P_FLUSH));
      check("done",  done, 64'(m_phase == P_DONE));
      check("wcount", word_count, 64'(m_count));
      check("wrt_ena", wrt_ena, 64'(m_wena));
      check("wrt_addrs", wrt_addrs, 64'(m_addr));
      check("dat_in", dat_in, 64'(m_data));
      if (wrt_ena === 1'b1) begin
         ram[wrt_addrs] = dat_in;
         if (exp_q.size() == 0) begin
            check("wr_unexpected", 64'(1), 64'(0));
         end else begin
            e = exp_q.pop_front();
            check("wr_scoreboard", {wrt_addrs, dat_in}, e);
         end
      end
   endtask

   // One clock: drive inputs, advance the model, and compare after the edge.
   task automatic cycle(input logic st, input logic tr, input logic vl, input logic [W-1:0] d);
      logic acc;
      start        = st;
      trig         = tr;
      sample_valid = vl;
      sample_in    = d;
      acc    = (m_phase == P_ACQ) && vl;
      m_wena = acc;
      if (acc) begin
         exp_q.push_back({m_count[AB-1:0], d});
         exp_ram[m_count[AB-1:0]] = d;
         m_addr  = m_count[AB-1:0];
         m_data  = d;
         m_count = m_count + 1;
      end
      case (m_phase)
         P_IDLE, P_DONE: begin
            if (st) begin
               m_phase = P_ARMED;
               m_count = 0;
            end
         end
`ifdef ACQ_TRIGGER_EN
         P_ARMED: if (tr) m_phase = P_ACQ;
`else
         P_ARMED: m_phase = P_ACQ;
`endif
         P_ACQ:   if (m_count == DEPTH) m_phase = P_FLUSH;
         P_FLUSH: m_phase = P_DONE;
         default: m_phase = P_IDLE;
      endcase
      @(posedge clk);
      @(negedge clk);
      observe();
   endtask

   // Run one capture from the current point until the model reaches DONE.
   // pat: 0 back-to-back, 1 valid 1,0,0,1 repeating, 2 random valid.
   // start_at5 pulses Start while WordCount is 5.
   task automatic run_capture(input int pat, input bit start_at5, input logic [W-1:0] base);
      int k;
      int budget;
      logic vl;
      logic st;
      logic [W-1:0] nxt;
      nxt    = base;
      k      = 0;
      budget = 400;
      while (m_phase != P_DONE && budget > 0) begin
         case (pat)
            0:       vl = 1'b1;
            1:       vl = ((k % 4) == 0) || ((k % 4) == 3);
            default: vl = 1'($urandom_range(0, 1));
         endcase
         st = start_at5 && (m_phase == P_ACQ) && (m_count == 5);
         if (m_phase == P_ACQ) k++;
         cycle(st, 1'b1, vl, nxt);
         if (m_wena) nxt = nxt + 1;
         budget--;
      end
      check("capture_in_budget", 64'(budget > 0), 64'(1));
      check("capture_done", done, 64'(1));
      check("capture_wcount", word_count, 64'(DEPTH));
      for (int i = 0; i < DEPTH; i++) check("ram_image", ram[i], exp_ram[i]);
      check("sb_empty", 64'(exp_q.size()), 64'(0));
   endtask

   initial begin
      rst_n        = 1'b0;
      start        = 1'b0;
      trig         = 1'b0;
      sample_valid = 1'b0;
      sample_in    = '0;
      model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         ram[i]     = '0;
         exp_ram[i] = '0;
      end
      #12;
      observe();
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b0, 1'b0, 1'b1, 32'hdead_beef);
      observe();

      // Back-to-back capture of 0x1000..0x100F.
      cycle(1'b1, 1'b1, 1'b0, '0);
      run_capture(0, 1'b0, 32'h0000_1000);
      for (int i = 0; i < DEPTH; i++) check("ram_1000", ram[i], 64'(32'h1000 + i));
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 32'h5555_0000);

      // Gappy valid pattern; Start pulsed at WordCount 5 must be ignored.
      cycle(1'b1, 1'b0, 1'b0, '0);
      run_capture(1, 1'b1, 32'h2000_0000);
      cycle(1'b1, 1'b0, 1'b0, '0);
      check("restart_wcount", word_count, 64'(0));
      check("restart_done", done, 64'(0));
      check("restart_busy", busy, 64'(1));

`ifdef ACQ_TRIGGER_EN
      // Trigger held low: armed, no acceptance, no writes.
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, 32'h7777_0000 + i);
      check("armed_hold_busy", busy, 64'(1));
      check("armed_hold_ready", sample_ready, 64'(0));
      cycle(1'b0, 1'b1, 1'b1, 32'h7777_1111);
      check("trig_ready", sample_ready, 64'(1));
`else
      // Trigger compiled out: ready follows one ARMED cycle regardless of Trig.
      cycle(1'b0, 1'b0, 1'b1, 32'h7777_0000);
      check("notrig_ready", sample_ready, 64'(1));
`endif
      run_capture(0, 1'b0, 32'h3000_0000);

      // Mid-capture asynchronous reset after 7 accepted samples.
      cycle(1'b1, 1'b0, 1'b0, '0);
      begin
         int guard;
         guard = 0;
         while (m_count < 7 && guard < 100) begin
            cycle(1'b0, 1'b1, 1'b1, 32'h4000_0000 + guard);
            guard++;
         end
         check("seven_accepts", word_count, 64'(7));
      end
      sample_valid = 1'b1;
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      observe();
      check("rst_wrt_ena", wrt_ena, 64'(0));
      check("rst_ready", sample_ready, 64'(0));
      @(posedge clk);
      @(negedge clk);
      observe();
      rst_n = 1'b1;
      cycle(1'b0, 1'b1, 1'b1, 32'h4400_0000);
      cycle(1'b1, 1'b1, 1'b0, '0);
      run_capture(0, 1'b0, 32'h5000_0000);
      check("rst_restart_addr0", ram[0], 64'(32'h5000_0000));

      // Randomized captures with Start/Trig noise and idle cycles in DONE.
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < int'($urandom_range(0, 3)); i++)
            cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
         cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
         begin
            int guard;
            guard = 0;
            while (m_phase != P_DONE && guard < 400) begin
               cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), $urandom);
               guard++;
            end
            check("rand_in_budget", 64'(guard < 400), 64'(1));
         end
         check("rand_done", done, 64'(1));
         for (int i = 0; i < DEPTH; i++) check("rand_ram", ram[i], exp_ram[i]);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
